yasac_host: RTL

//  Host-side sequencer for the YASAC processor's port and START/RDY interface.
//  - Drives the CPU input ports PORT08..PORT15.
//  - Pulses START and waits for the run to complete via RDY.
//  - Captures the CPU output ports PORT00..PORT07 into readable result registers.
//  - Sits between a test/host bus and one yasac instance.

---
 rtl/yasac_host.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/yasac_host.sv
// Host-side sequencer for one yasac core: loads the CPU input ports from
// shadow registers, pulses START, waits for RDY to complete a run, and
// captures the CPU output ports into readable result registers.
module yasac_host #(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_W          = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             WR_EN,
    input  logic [2:0]       WR_ADDR,
    input  logic [7:0]       WR_DATA,
    input  logic             GO,
    input  logic [2:0]       RD_ADDR,
    output logic [7:0]       RD_DATA,
    output logic             BUSY,
    output logic             DONE,
    output logic             ERR,
    output logic [CNT_W-1:0] RUN_COUNT,
    output logic             CPU_START,
    input  logic             CPU_RDY,
    output logic [7:0]       CPU_IN0,
    output logic [7:0]       CPU_IN1,
    output logic [7:0]       CPU_IN2,
    output logic [7:0]       CPU_IN3,
    output logic [7:0]       CPU_IN4,
    output logic [7:0]       CPU_IN5,
    output logic [7:0]       CPU_IN6,
    output logic [7:0]       CPU_IN7,
    input  logic [7:0]       CPU_OUT0,
    input  logic [7:0]       CPU_OUT1,
    input  logic [7:0]       CPU_OUT2,
    input  logic [7:0]       CPU_OUT3,
    input  logic [7:0]       CPU_OUT4,
    input  logic [7:0]       CPU_OUT5,
    input  logic [7:0]       CPU_OUT6,
    input  logic [7:0]       CPU_OUT7
);

    typedef enum logic [2:0] {
        S_IDLE, S_ARM, S_LOAD, S_PULSE, S_RUN, S_CAPT
    } state_t;

    state_t           state_q;
    logic [7:0]       shadow_q [8];
    logic [7:0]       cpu_in_q [8];
    logic [7:0]       res_q    [8];
    logic [7:0]       cpu_out_w[8];
    logic             start_q, done_q, err_q, seen_low_q;
    logic [CNT_W-1:0] cnt_q, cnt_d, run_cnt_q;
    logic             tmo;

    assign cpu_out_w[0] = CPU_OUT0;
    assign cpu_out_w[1] = CPU_OUT1;
    assign cpu_out_w[2] = CPU_OUT2;
    assign cpu_out_w[3] = CPU_OUT3;
    assign cpu_out_w[4] = CPU_OUT4;
    assign cpu_out_w[5] = CPU_OUT5;
    assign cpu_out_w[6] = CPU_OUT6;
    assign cpu_out_w[7] = CPU_OUT7;

    // Timeout fires on the ARM/RUN cycle that brings the count to the limit.
    assign cnt_d = cnt_q + CNT_W'(1);
    assign tmo   = (TIMEOUT_CYCLES != 0) && (cnt_d == CNT_W'(TIMEOUT_CYCLES));

    // Shadow registers accept host writes in every state.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < 8; i++) shadow_q[i] <= '0;
        end else if (WR_EN) begin
            shadow_q[WR_ADDR] <= WR_DATA;
        end
    end

    // Run sequencer: all FSM outputs are registered here.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            start_q    <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            seen_low_q <= 1'b0;
            cnt_q      <= '0;
            run_cnt_q  <= '0;
            for (int i = 0; i < 8; i++) begin
                cpu_in_q[i] <= '0;
                res_q[i]    <= '0;
            end
        end else begin
            start_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                S_IDLE: if (GO) begin
                    err_q   <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= S_ARM;
                end
                S_ARM: begin
                    cnt_q <= cnt_d;
                    if (CPU_RDY) begin
                        state_q <= S_LOAD;
                    end else if (tmo) begin
                        err_q   <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
                S_LOAD: begin
                    // Old shadow values are copied; a same-cycle write lands after.
                    for (int i = 0; i < 8; i++) cpu_in_q[i] <= shadow_q[i];
                    start_q <= 1'b1;
                    state_q <= S_PULSE;
                end
                S_PULSE: begin
                    seen_low_q <= 1'b0;
                    state_q    <= S_RUN;
                end
                S_RUN: begin
                    cnt_q <= cnt_d;
                    if (!CPU_RDY) seen_low_q <= 1'b1;
                    // RDY must have dropped after START before a high counts.
                    if (CPU_RDY && seen_low_q) begin
                        state_q <= S_CAPT;
                    end else if (tmo) begin
                        err_q   <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
                S_CAPT: begin
                    for (int i = 0; i < 8; i++) res_q[i] <= cpu_out_w[i];
                    done_q    <= 1'b1;
                    run_cnt_q <= run_cnt_q + CNT_W'(1);
                    state_q   <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign RD_DATA   = res_q[RD_ADDR];
    assign BUSY      = (state_q != S_IDLE);
    assign DONE      = done_q;
    assign ERR       = err_q;
    assign RUN_COUNT = run_cnt_q;
    assign CPU_START = start_q;
    assign CPU_IN0   = cpu_in_q[0];
    assign CPU_IN1   = cpu_in_q[1];
    assign CPU_IN2   = cpu_in_q[2];
    assign CPU_IN3   = cpu_in_q[3];
    assign CPU_IN4   = cpu_in_q[4];
    assign CPU_IN5   = cpu_in_q[5];
    assign CPU_IN6   = cpu_in_q[6];
    assign CPU_IN7   = cpu_in_q[7];

endmodule
